// File: rtl/key_pkg.sv
// Shared defaults and key level constants for the key/LED bank.
package key_pkg;

    localparam int unsigned DEFAULT_CH      = 4;
    localparam int unsigned DEFAULT_CNT_MAX = 1_000_000;

    // Keys are wired active-low.
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce counter, stable level and
// registered press strobe.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic sys_clock,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_stable,
    output logic press_pulse,
    output logic press_evt
);

    localparam int unsigned      CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(CNT_MAX - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          stable_prev_q, stable_prev_d;
    logic [1:0]    vld_q, vld_d;
    logic          armed_q, armed_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync1_d       = key_raw;
        sync2_d       = sync1_q;
        cnt_d         = cnt_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        vld_d         = {vld_q[0], 1'b1};

        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A channel only produces strobes once a genuine release has been
        // seen since reset, so a key held across reset never reports a press.
        armed_d = armed_q | (vld_q[1] & (sync2_q == KEY_RELEASED));
        pulse_d = armed_q & (stable_prev_q == KEY_RELEASED) & (stable_q == KEY_PRESSED);
    end

    always_ff @(posedge sys_clock) begin
        if (!sys_rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            cnt_q         <= '0;
            stable_q      <= KEY_RELEASED;
            stable_prev_q <= KEY_RELEASED;
            vld_q         <= '0;
            armed_q       <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            vld_q         <= vld_d;
            armed_q       <= armed_d;
            pulse_q       <= pulse_d;
        end
    end

    assign key_stable  = stable_q;
    assign press_pulse = pulse_q;
    assign press_evt   = pulse_d;

endmodule

// File: rtl/key_led_bank.sv
// Bank of debounced keys driving LEDs, each channel in follow or toggle mode.
module key_led_bank
    import key_pkg::*;
#(
    parameter int unsigned CH      = DEFAULT_CH,
    parameter int unsigned CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic          sys_clock,
    input  logic          sys_rst_n,
    input  logic [CH-1:0] key_in,
    input  logic [CH-1:0] mode_toggle,
    output logic [CH-1:0] key_stable,
    output logic [CH-1:0] press_pulse,
    output logic [CH-1:0] led_out
);

    logic [CH-1:0] press_evt;
    logic [CH-1:0] led_q, led_d;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        key_debounce #(
            .CNT_MAX(CNT_MAX)
        ) u_deb (
            .sys_clock  (sys_clock),
            .sys_rst_n  (sys_rst_n),
            .key_raw    (key_in[g]),
            .key_stable (key_stable[g]),
            .press_pulse(press_pulse[g]),
            .press_evt  (press_evt[g])
        );
    end

    // Toggle mode flips on the same edge that registers the press strobe.
    always_comb begin
        led_d = led_q;
        for (int unsigned i = 0; i < CH; i++) begin
            if (mode_toggle[i]) begin
                led_d[i] = led_q[i] ^ press_evt[i];
            end else begin
                led_d[i] = ~key_stable[i];
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (!sys_rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_key_led_bank.sv
// Bench for key_led_bank: vector table, directed corner sequences and random
// stimulus against a window-based reference model.
module tb_key_led_bank;

    localparam int unsigned CH      = 4;
    localparam int unsigned CNT_MAX = 4;

    logic          sys_clock = 1'b0;
    logic          sys_rst_n;
    logic [CH-1:0] key_in;
    logic [CH-1:0] mode_toggle;
    logic [CH-1:0] key_stable;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] led_out;

    int n_checks = 0;
    int n_fail   = 0;

    key_led_bank #(
        .CH     (CH),
        .CNT_MAX(CNT_MAX)
    ) dut (
        .sys_clock  (sys_clock),
        .sys_rst_n  (sys_rst_n),
        .key_in     (key_in),
        .mode_toggle(mode_toggle),
        .key_stable (key_stable),
        .press_pulse(press_pulse),
        .led_out    (led_out)
    );

    always #5 sys_clock = ~sys_clock;

    // Reference model: a key level is accepted once the last CNT_MAX
    // synchronized samples all disagree with the current stable level.
    logic [CH-1:0]      m_s1, m_s2, m_stable, m_fell, m_armed, m_pulse, m_led;
    logic [CNT_MAX-1:0] win   [CH];
    int unsigned        wfill [CH];
    int unsigned        m_vcnt;

    task automatic model_edge(input logic [CH-1:0] k, input logic [CH-1:0] md, input logic rn);
        logic [CH-1:0] n_stable, n_fell, n_armed, n_pulse, n_led;
        if (!rn) begin
            m_s1 = '1; m_s2 = '1; m_stable = '1; m_fell = '0;
            m_armed = '0; m_pulse = '0; m_led = '0; m_vcnt = 0;
            for (int i = 0; i < CH; i++) begin
                win[i]   = '0;
                wfill[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                n_pulse[i] = m_fell[i] & m_armed[i];
                n_armed[i] = m_armed[i] | ((m_vcnt >= 2) && m_s2[i]);
                win[i] = {win[i][CNT_MAX-2:0], m_s2[i]};
                if (wfill[i] < CNT_MAX) wfill[i]++;
                n_stable[i] = m_stable[i];
                if (wfill[i] == CNT_MAX && win[i] == {CNT_MAX{~m_stable[i]}})
                    n_stable[i] = m_s2[i];
                n_fell[i] = m_stable[i] & ~n_stable[i];
                n_led[i]  = md[i] ? (m_led[i] ^ n_pulse[i]) : ~m_stable[i];
            end
            m_s2 = m_s1; m_s1 = k;
            m_stable = n_stable; m_fell = n_fell; m_armed = n_armed;
            m_pulse = n_pulse; m_led = n_led;
            if (m_vcnt < 2) m_vcnt++;
        end
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT samples, then
    // compare all outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge sys_clock);
        model_edge(key_in, mode_toggle, sys_rst_n);
        #1;
        check("model_stable", key_stable, m_stable);
        check("model_pulse", press_pulse, m_pulse);
        check("model_led", led_out, m_led);
    endtask

    typedef struct {
        logic [CH-1:0] key;
        logic [CH-1:0] mode;
        logic [CH-1:0] stable;
        logic [CH-1:0] pulse;
        logic [CH-1:0] led;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int pulses;

        // Channel 0 press then release, follow mode.
        for (int r = 0; r < 5; r++)  vecs[r] = '{4'b1110, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        vecs[5] = '{4'b1110, 4'b0000, 4'b1110, 4'b0000, 4'b0000};
        vecs[6] = '{4'b1110, 4'b0000, 4'b1110, 4'b0001, 4'b0001};
        vecs[7] = '{4'b1110, 4'b0000, 4'b1110, 4'b0000, 4'b0001};
        for (int r = 8; r < 13; r++) vecs[r] = '{4'b1111, 4'b0000, 4'b1110, 4'b0000, 4'b0001};
        vecs[13] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0001};
        vecs[14] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000};

        // Reset held 3 cycles with every key pressed.
        sys_rst_n = 1'b0; key_in = 4'b0000; mode_toggle = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_stable", key_stable, 4'b1111);
            check("rst_pulse", press_pulse, 4'b0000);
            check("rst_led", led_out, 4'b0000);
        end
        sys_rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("held_no_pulse", press_pulse, 4'b0000);
        end
        check("held_stable", key_stable, 4'b0000);
        check("held_led", led_out, 4'b1111);
        key_in = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("held_rel_no_pulse", press_pulse, 4'b0000);
        end
        check("idle_led", led_out, 4'b0000);

        // Vector table.
        for (int r = 0; r < 15; r++) begin
            key_in = vecs[r].key; mode_toggle = vecs[r].mode;
            tick();
            check($sformatf("vec%0d_stable", r), key_stable, vecs[r].stable);
            check($sformatf("vec%0d_pulse", r), press_pulse, vecs[r].pulse);
            check($sformatf("vec%0d_led", r), led_out, vecs[r].led);
        end

        // Three-cycle glitch on channel 1.
        key_in = 4'b1101;
        for (int c = 0; c < 3; c++) tick();
        key_in = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("glitch_stable1", key_stable & 4'b0010, 4'b0010);
            check("glitch_pulse1", press_pulse & 4'b0010, 4'b0000);
            check("glitch_led1", led_out & 4'b0010, 4'b0000);
        end

        // Toggle mode on channel 2: two press/release pairs.
        mode_toggle = 4'b0100;
        for (int p = 0; p < 2; p++) begin
            pulses = 0;
            key_in = 4'b1011;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (press_pulse[2]) pulses++;
            end
            check("tog_press_pulses", 4'(pulses), 4'd1);
            check("tog_after_press", led_out & 4'b0100, (p == 0) ? 4'b0100 : 4'b0000);
            key_in = 4'b1111;
            for (int c = 0; c < 8; c++) begin
                tick();
                check("tog_rel_no_pulse", press_pulse & 4'b0100, 4'b0000);
            end
            check("tog_after_rel", led_out & 4'b0100, (p == 0) ? 4'b0100 : 4'b0000);
        end
        mode_toggle = 4'b0000;
        for (int c = 0; c < 3; c++) tick();

        // All four keys pressed on the same cycle.
        key_in = 4'b0000;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (press_pulse != 4'b0000) pulses++;
            if (c == 6) check("all_pulse_e6", press_pulse, 4'b1111);
        end
        check("all_pulse_count", 4'(pulses), 4'd1);
        key_in = 4'b1111;
        for (int c = 0; c < 10; c++) tick();

        // Reset in the middle of a channel-3 debounce, key kept pressed.
        key_in = 4'b0111;
        for (int c = 0; c < 3; c++) tick();
        sys_rst_n = 1'b0;
        tick();
        check("midrst_stable", key_stable, 4'b1111);
        check("midrst_pulse", press_pulse, 4'b0000);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            check("midrst_no_pulse3", press_pulse & 4'b1000, 4'b0000);
        end
        check("midrst_stable3", key_stable & 4'b1000, 4'b0000);
        key_in = 4'b1111;
        for (int c = 0; c < 8; c++) tick();
        key_in = 4'b0111;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (press_pulse[3]) pulses++;
        end
        check("repress_pulse3", 4'(pulses), 4'd1);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 9) == 0) key_in[i] = ~key_in[i];
                if ($urandom_range(0, 63) == 0) mode_toggle[i] = ~mode_toggle[i];
            end
            sys_rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
